aes_job_fifo: RTL and testbench

//  Buffers complete encryption jobs (key, nonce, destination, plain_text) captured by

---
 rtl/aes_pkg.sv | 22 ++
 rtl/fifo_ptr_ctrl.sv | 77 +++++++
 rtl/aes_job_fifo.sv | 99 +++++++++
 tb/tb_aes_job_fifo.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared widths and the job record buffered ahead of the
//               AES-CTR core.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int AHB_BUS_SIZE = 32;
  localparam int BLOCK_W      = 128;

  // One complete encryption job, 416 bits; key sits in the top bits.
  typedef struct packed {
    logic [BLOCK_W-1:0]      key;
    logic [BLOCK_W-1:0]      nonce;
    logic [AHB_BUS_SIZE-1:0] destination;
    logic [BLOCK_W-1:0]      plain_text;
  } aes_job_t;

endpackage
`default_nettype wire

// File: rtl/fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ptr_ctrl
// Description : Read/write pointers with explicit wrap, occupancy count,
//               registered full flag and sticky overflow for a DEPTH-entry
//               FIFO (DEPTH need not be a power of two).
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr_ctrl
  import aes_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_req_i,
  input  logic             pop_req_i,
  output logic             push_o,
  output logic             pop_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             full_q,   full_d;
  logic             ovf_q,    ovf_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake qualification and next-state for pointers, count and flags.
  // A write while full is dropped even if a pop happens in the same cycle.
  always_comb begin
    push_o   = push_req_i && !full_q;
    pop_o    = (count_q != '0) && pop_req_i;
    wr_ptr_d = push_o ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_o  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_o) - CNT_W'(pop_o);
    full_d   = (count_d == CNT_W'(DEPTH));
    ovf_d    = ovf_q | (push_req_i & full_q);
  end

  // State register with synchronous reset discarding all entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  assign wr_ptr_o   = wr_ptr_q;
  assign rd_ptr_o   = rd_ptr_q;
  assign count_o    = count_q;
  assign full_o     = full_q;
  assign empty_o    = (count_q == '0);
  assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: rtl/aes_job_fifo.sv
`default_nettype none
// ============================================================================
// Module      : aes_job_fifo
// Description : Show-ahead FIFO of complete AES-CTR jobs between slave_write
//               and the AES core, with a flag telling the core when the head
//               job's key differs from the last key it consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_job_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int AHB_BUS_SIZE = 32
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  input  logic                        write_out,
  input  logic [127:0]                key,
  input  logic [127:0]                nonce,
  input  logic [AHB_BUS_SIZE-1:0]     destination,
  input  logic [127:0]                plain_text,
  output logic                        fifo_full,
  output logic                        job_valid,
  input  logic                        job_ready,
  output logic [127:0]                job_key,
  output logic [127:0]                job_nonce,
  output logic [AHB_BUS_SIZE-1:0]     job_destination,
  output logic [127:0]                job_plain_text,
  output logic                        job_new_key,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_count,
  output logic                        overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  aes_job_t         mem [DEPTH];
  aes_job_t         w_in_job;
  aes_job_t         w_head;
  logic             w_push, w_pop, w_empty;
  logic [PTR_W-1:0] w_wr_ptr, w_rd_ptr;
  logic [127:0]     last_key_q;
  logic             last_key_valid_q;

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_ptr (
    .clk        (HCLK),
    .rst        (HRESET),
    .push_req_i (write_out),
    .pop_req_i  (job_ready),
    .push_o     (w_push),
    .pop_o      (w_pop),
    .wr_ptr_o   (w_wr_ptr),
    .rd_ptr_o   (w_rd_ptr),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (w_empty),
    .overflow_o (overflow)
  );

  assign w_in_job.key         = key;
  assign w_in_job.nonce       = nonce;
  assign w_in_job.destination = destination[31:0];
  assign w_in_job.plain_text  = plain_text;

  // Job storage; contents need no reset because the count gates visibility.
  always_ff @(posedge HCLK) begin
    if (w_push) begin
      mem[w_wr_ptr] <= w_in_job;
    end
  end

  // Remember the key of the most recently consumed job.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      last_key_valid_q <= 1'b0;
    end else if (w_pop) begin
      last_key_q       <= w_head.key;
      last_key_valid_q <= 1'b1;
    end
  end

  // Show-ahead head read, zeroed while the FIFO is empty.
  always_comb begin
    job_valid = !w_empty;
    w_head    = job_valid ? mem[w_rd_ptr] : '0;
  end

  assign job_key         = w_head.key;
  assign job_nonce       = w_head.nonce;
  assign job_destination = AHB_BUS_SIZE'(w_head.destination);
  assign job_plain_text  = w_head.plain_text;
  assign job_new_key     = job_valid && (!last_key_valid_q || (w_head.key != last_key_q));

endmodule
`default_nettype wire

// File: tb/tb_aes_job_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_job_fifo
// Description : Self-checking bench for aes_job_fifo: a table of single-cycle
//               steps with expected post-edge state, then hand sequences for
//               ordering/wrap, full-with-pop and pop-while-empty.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_job_fifo;

  localparam logic [127:0] KA = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] KB = 128'hDEADBEEF_00000001_CAFEF00D_00000002;
  localparam logic [127:0] KC = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic         HCLK = 1'b0;
  logic         HRESET, write_out, job_ready;
  logic [127:0] key, nonce, plain_text;
  logic [31:0]  destination;
  logic         fifo_full, job_valid, job_new_key, overflow;
  logic [127:0] job_key, job_nonce, job_plain_text;
  logic [31:0]  job_destination;
  logic [2:0]   fifo_count;

  int checks   = 0;
  int failures = 0;

  aes_job_fifo #(.DEPTH(4), .AHB_BUS_SIZE(32)) dut (
    .HCLK            (HCLK),
    .HRESET          (HRESET),
    .write_out       (write_out),
    .key             (key),
    .nonce           (nonce),
    .destination     (destination),
    .plain_text      (plain_text),
    .fifo_full       (fifo_full),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_key         (job_key),
    .job_nonce       (job_nonce),
    .job_destination (job_destination),
    .job_plain_text  (job_plain_text),
    .job_new_key     (job_new_key),
    .fifo_count      (fifo_count),
    .overflow        (overflow)
  );

  always #5 HCLK = ~HCLK;

  // Nonce and plaintext are derived from the destination so each job is unique.
  function automatic logic [127:0] nf(input logic [31:0] d);
    return {d, ~d, d ^ 32'h5A5A5A5A, d ^ 32'hC0FFEE00};
  endfunction
  function automatic logic [127:0] pf(input logic [31:0] d);
    return {~d, d, d + 32'd1, d};
  endfunction

  typedef struct packed {
    logic         rst;
    logic         wr;
    logic [127:0] k;
    logic [31:0]  d;
    logic         rdy;
    logic [2:0]   cnt;
    logic         vld;
    logic         full;
    logic         ovf;
    logic         nk;
    logic [127:0] hkey;
    logic [31:0]  hdest;
  } vec_t;

  vec_t vt [13];

  function automatic vec_t mk(input logic r, input logic w, input logic [127:0] k,
                              input logic [31:0] d, input logic rd, input logic [2:0] c,
                              input logic v, input logic f, input logic o, input logic n,
                              input logic [127:0] hk, input logic [31:0] hd);
    vec_t t;
    t.rst = r; t.wr = w; t.k = k; t.d = d; t.rdy = rd; t.cnt = c; t.vld = v;
    t.full = f; t.ovf = o; t.nk = n; t.hkey = hk; t.hdest = hd;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Drive inputs away from the edge, clock once, sample 1 time unit later.
  task automatic cyc(input logic r, input logic w, input logic [127:0] k,
                     input logic [31:0] d, input logic rd);
    @(negedge HCLK);
    HRESET = r; write_out = w; key = k; destination = d;
    nonce = nf(d); plain_text = pf(d); job_ready = rd;
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk_state(input string nm, input logic [2:0] c, input logic v,
                           input logic f, input logic o);
    chk({nm, ".count"}, 128'(fifo_count), 128'(c));
    chk({nm, ".valid"}, 128'(job_valid), 128'(v));
    chk({nm, ".full"},  128'(fifo_full), 128'(f));
    chk({nm, ".ovf"},   128'(overflow),  128'(o));
  endtask

  task automatic chk_head(input string nm, input logic v, input logic [127:0] k,
                          input logic [31:0] d, input logic n);
    chk({nm, ".key"},   job_key,                 v ? k     : 128'h0);
    chk({nm, ".dest"},  128'(job_destination),   v ? 128'(d) : 128'h0);
    chk({nm, ".nonce"}, job_nonce,               v ? nf(d) : 128'h0);
    chk({nm, ".plain"}, job_plain_text,          v ? pf(d) : 128'h0);
    chk({nm, ".newkey"}, 128'(job_new_key),      128'(n));
  endtask

  initial begin
    HRESET = 1'b1; write_out = 1'b0; job_ready = 1'b0;
    key = '0; nonce = '0; plain_text = '0; destination = '0;

    //        rst wr key dest          rdy cnt v f o nk head key  head dest
    vt[0]  = mk(1, 0, KB, 32'h0,        0, 0, 0, 0, 0, 0, '0, 32'h0);
    vt[1]  = mk(0, 1, KA, 32'h10101010, 0, 1, 1, 0, 0, 1, KA, 32'h10101010);
    vt[2]  = mk(0, 0, KB, 32'h0,        0, 1, 1, 0, 0, 1, KA, 32'h10101010);
    vt[3]  = mk(0, 1, KB, 32'h2,        0, 2, 1, 0, 0, 1, KA, 32'h10101010);
    vt[4]  = mk(0, 1, KB, 32'h3,        0, 3, 1, 0, 0, 1, KA, 32'h10101010);
    vt[5]  = mk(0, 1, KB, 32'h4,        0, 4, 1, 1, 0, 1, KA, 32'h10101010);
    vt[6]  = mk(0, 1, KC, 32'h5,        0, 4, 1, 1, 1, 1, KA, 32'h10101010);
    vt[7]  = mk(0, 0, KC, 32'h0,        1, 3, 1, 0, 1, 1, KB, 32'h2);
    vt[8]  = mk(0, 0, KC, 32'h0,        1, 2, 1, 0, 1, 0, KB, 32'h3);
    vt[9]  = mk(0, 1, KC, 32'h6,        1, 2, 1, 0, 1, 0, KB, 32'h4);
    vt[10] = mk(0, 0, KA, 32'h0,        1, 1, 1, 0, 1, 1, KC, 32'h6);
    vt[11] = mk(1, 0, KA, 32'h0,        0, 0, 0, 0, 0, 0, '0, 32'h0);
    vt[12] = mk(0, 1, KC, 32'h7,        0, 1, 1, 0, 0, 1, KC, 32'h7);

    for (int i = 0; i < 13; i++) begin
      cyc(vt[i].rst, vt[i].wr, vt[i].k, vt[i].d, vt[i].rdy);
      chk_state($sformatf("vec%0d", i), vt[i].cnt, vt[i].vld, vt[i].full, vt[i].ovf);
      chk_head($sformatf("vec%0d", i), vt[i].vld, vt[i].hkey, vt[i].hdest, vt[i].nk);
    end

    // Ordering and wrap: preload 1..3, then pop i while pushing i+3 (up to 6).
    cyc(1, 0, KA, 32'h0, 0);
    for (int i = 1; i <= 3; i++) cyc(0, 1, KA, 32'(i), 0);
    chk_state("wrap.pre", 3, 1, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      chk_head($sformatf("wrap%0d", i), 1, KA, 32'(i), (i == 1));
      cyc(0, (i + 3 <= 6), KA, 32'(i + 3), 1);
    end
    chk_state("wrap.post", 0, 0, 0, 0);
    chk_head("wrap.post", 0, '0, 32'h0, 0);

    // Full with a simultaneous pop: the write is still dropped.
    cyc(1, 0, KA, 32'h0, 0);
    for (int i = 1; i <= 4; i++) cyc(0, 1, KB, 32'(i), 0);
    chk_state("fullpop.pre", 4, 1, 1, 0);
    cyc(0, 1, KC, 32'h9, 1);
    chk_state("fullpop", 3, 1, 0, 1);
    chk_head("fullpop", 1, KB, 32'h2, 0);
    for (int i = 2; i <= 4; i++) cyc(0, 0, KA, 32'h0, 1);
    chk_state("fullpop.drain", 0, 0, 0, 1);

    // job_ready while empty is ignored; then a fresh job after reset is new-key.
    cyc(1, 0, KA, 32'h0, 0);
    cyc(0, 0, KA, 32'h0, 1);
    chk_state("emptyrdy", 0, 0, 0, 0);
    cyc(0, 1, KA, 32'h11, 1);
    chk_state("emptypush", 1, 1, 0, 0);
    chk_head("emptypush", 1, KA, 32'h11, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
